// File: rtl/axis_fifo_if.sv
// -----------------------------------------------------------------------------
// axis_if
//   Minimal AXI-Stream handshake bundle (tvalid / tready / tdata).
//
//   Parameters:
//     TDATA_WIDTH  width of tdata in bits
//
//   Modports:
//     s  subordinate (receiving) side : tvalid, tdata in ; tready out
//     m  manager (sending) side       : tvalid, tdata out; tready in
// -----------------------------------------------------------------------------
interface axis_if #(
  parameter int TDATA_WIDTH = 8
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport s (input tvalid, input tdata, output tready);
  modport m (output tvalid, output tdata, input tready);
endinterface

// File: rtl/axis_fifo.sv
// -----------------------------------------------------------------------------
// axis_fifo
//   AXI-Stream FIFO with synchronous flush. Sits behind the pipeline register
//   slice so that downstream decode/issue can stall without back-pressuring
//   the slice every cycle. flush shares its source with the slice so both
//   stages drop in-flight beats on the same cycle.
//
//   Parameters:
//     DEPTH        number of entries, power of two >= 2
//     (TDATA_WIDTH is taken from the axis_sif interface instance)
//
//   Ports:
//     clk       clock, all state changes on the rising edge
//     rst       synchronous active-high reset (priority over flush)
//     axis_sif  write side: tvalid/tdata in, tready out
//     axis_mif  read side : tvalid/tdata out, tready in
//     flush     drop all stored entries; any push/pop in that cycle is lost
//     count     current occupancy, 0..DEPTH
//
//   Build option:
//     AXIS_FIFO_BYPASS_EN  when defined, an empty FIFO forwards the write
//                          side straight to the read side combinationally.
//                          When undefined, the read side is purely
//                          registered and latency is always one cycle.
// -----------------------------------------------------------------------------
module axis_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  axis_if.s                      axis_sif,
  axis_if.m                      axis_mif,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int TDATA_WIDTH = axis_sif.TDATA_WIDTH;
  localparam int AW          = $clog2(DEPTH);
  localparam int PW          = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  // Elaboration-time parameter checks.
  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
      $fatal(1, "axis_fifo: DEPTH must be a power of two and at least 2");
    end
    if (axis_mif.TDATA_WIDTH != TDATA_WIDTH) begin : g_width_chk
      $fatal(1, "axis_fifo: axis_sif and axis_mif TDATA_WIDTH differ");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Pointers carry one extra wrap bit so that full and empty differ without
  // a separate flag: occupancy is simply their modulo difference.
  logic [PW-1:0]          wp_reg;
  logic [PW-1:0]          rp_reg;
  logic [TDATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wp_idx;
  logic [AW-1:0] rp_idx;
  logic [PW-1:0] occ;
  logic          empty;
  logic          full;

  assign wp_idx = wp_reg[AW-1:0];
  assign rp_idx = rp_reg[AW-1:0];
  assign occ    = wp_reg - rp_reg;
  assign empty  = (occ == '0);
  assign full   = (occ == DEPTH_P);
  assign count  = occ;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  logic push;
  logic pop;
  logic pass_through;
  logic wr_en;
  logic rd_en;

  // Ready to accept depends only on registered occupancy (and rst), never on
  // the downstream tready, so no combinational ready chain forms.
  assign axis_sif.tready = !full && !rst;

`ifdef AXIS_FIFO_BYPASS_EN
  logic bypass_sel;

  // While empty the write side is mirrored onto the read side. If the
  // consumer takes it right away the beat never touches the storage.
  assign bypass_sel      = empty && !flush && !rst;
  assign axis_mif.tvalid = bypass_sel ? axis_sif.tvalid : !empty;
  assign axis_mif.tdata  = bypass_sel ? axis_sif.tdata  : mem[rp_idx];
  assign pass_through    = bypass_sel && axis_sif.tvalid && axis_mif.tready;
`else
  assign axis_mif.tvalid = !empty;
  assign axis_mif.tdata  = mem[rp_idx];
  assign pass_through    = 1'b0;
`endif

  assign push = axis_sif.tvalid && axis_sif.tready;
  assign pop  = axis_mif.tvalid && axis_mif.tready;

  // A flush swallows both sides of the cycle: the source believes its beat
  // was taken and the consumer believes it took one, but neither is kept.
  assign wr_en = push && !pass_through && !flush;
  assign rd_en = pop && !empty && !flush;

  // ---------------------------------------------------------------------------
  // Pointer update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_reg <= '0;
      rp_reg <= '0;
    end else if (flush) begin
      wp_reg <= '0;
      rp_reg <= '0;
    end else begin
      if (wr_en) begin
        wp_reg <= wp_reg + ONE_P;
      end
      if (rd_en) begin
        rp_reg <= rp_reg + ONE_P;
      end
    end
  end

  // Storage has no reset; stale entries are never visible because tvalid is
  // derived from the pointers alone.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wp_idx] <= axis_sif.tdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Run-time checks
  // ---------------------------------------------------------------------------
  // A presented beat that is not taken stays presented with the same data,
  // unless a flush drops it.
  a_hold_stable : assert property (
    @(posedge clk) disable iff (rst)
      (axis_mif.tvalid && !axis_mif.tready && !flush)
        |=> (axis_mif.tvalid && $stable(axis_mif.tdata))
  );

  a_count_range : assert property (
    @(posedge clk) disable iff (rst) (occ <= DEPTH_P)
  );

  a_no_push_full : assert property (
    @(posedge clk) disable iff (rst) full |-> !axis_sif.tready
  );

endmodule

// File: tb/tb_axis_fifo.sv
module tb_axis_fifo;

  localparam int DEPTH = 4;
  localparam int W     = 8;
`ifdef AXIS_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic [$clog2(DEPTH):0] count;

  axis_if #(.TDATA_WIDTH(W)) sif ();
  axis_if #(.TDATA_WIDTH(W)) mif ();

  axis_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .axis_sif (sif),
    .axis_mif (mif),
    .flush    (flush),
    .count    (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the FIFO contents as a queue.
  // ---------------------------------------------------------------------------
  logic [W-1:0] q[$];
  logic [W-1:0] out_log[$];
  bit           started  = 1'b0;
  bit           acc_last = 1'b0;

  always @(posedge clk) begin
    bit           can_push;
    logic [W-1:0] d;
    acc_last = 1'b0;
    if (rst) begin
      q.delete();
      started = 1'b1;
    end else if (flush) begin
      if (sif.tvalid && q.size() < DEPTH) acc_last = 1'b1;
      q.delete();
      $display("t=%0t flush", $time);
    end else begin
      can_push = sif.tvalid && (q.size() < DEPTH);
      if (BYP && q.size() == 0 && can_push && mif.tready) begin
        out_log.push_back(sif.tdata);
        acc_last = 1'b1;
        $display("t=%0t beat out %02h (bypass)", $time, sif.tdata);
      end else begin
        if (mif.tready && q.size() > 0) begin
          d = q.pop_front();
          out_log.push_back(d);
          $display("t=%0t beat out %02h", $time, d);
        end
        if (can_push) begin
          q.push_back(sif.tdata);
          acc_last = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit exp_v;
    if (started) begin
      exp_v = (q.size() > 0) || (BYP && !rst && !flush && sif.tvalid);
      chk("sready", 32'(sif.tready), 32'(!rst && q.size() < DEPTH));
      chk("mvalid", 32'(mif.tvalid), 32'(exp_v));
      if (exp_v) chk("mdata", 32'(mif.tdata), 32'((q.size() > 0) ? q[0] : sif.tdata));
      chk("count", 32'(count), 32'(q.size()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] exp_fd [5];
    int           sent;
    int           cyc;
    int           errs;
    bit           hold;

    exp_fd[0] = 8'hA0; exp_fd[1] = 8'hA1; exp_fd[2] = 8'hA2;
    exp_fd[3] = 8'hA3; exp_fd[4] = 8'hB5;

    // Reset with a beat offered: nothing may be taken.
    rst = 1'b1; flush = 1'b0;
    sif.tvalid = 1'b1; sif.tdata = 8'h11; mif.tready = 1'b0;
    tick();
    chk("rst_sready", 32'(sif.tready), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mvalid", 32'(mif.tvalid), 32'd0);
    tick();
    rst = 1'b0; sif.tvalid = 1'b0;
    #1;
    chk("post_rst_sready", 32'(sif.tready), 32'd1);
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_mvalid", 32'(mif.tvalid), 32'd0);

    // Fill to full, then offer a fifth beat that must be held off.
    for (int i = 0; i < 4; i++) begin
      sif.tvalid = 1'b1; sif.tdata = W'(8'hA0 + i);
      tick();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_sready", 32'(sif.tready), 32'd0);
    sif.tdata = 8'hB5;
    tick();
    tick();
    chk("full_hold_count", 32'(count), 32'd4);
    chk("full_head", 32'(mif.tdata), 32'hA0);
    mif.tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("drain_valid", 32'(mif.tvalid), 32'd1);
      chk("drain_data", 32'(mif.tdata), 32'(exp_fd[k]));
      tick();
      if (acc_last) sif.tvalid = 1'b0;
    end
    mif.tready = 1'b0;
    #1;
    chk("drain_count", 32'(count), 32'd0);

    // Random streaming with an incrementing pattern.
    out_log.delete();
    sent = 0; cyc = 0; hold = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      if (!hold) begin
        sif.tvalid = 1'($urandom_range(0, 1));
        sif.tdata  = W'(sent);
      end
      mif.tready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
      if (acc_last) begin
        sent++;
        hold = 1'b0;
      end else begin
        hold = sif.tvalid;
      end
    end
    sif.tvalid = 1'b0; mif.tready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    chk("stream_sent", 32'(sent), 32'd1000);
    chk("stream_len", 32'(out_log.size()), 32'd1000);
    errs = 0;
    for (int i = 0; i < out_log.size(); i++)
      if (out_log[i] !== W'(i)) errs++;
    chk("stream_order", 32'(errs), 32'd0);
    mif.tready = 1'b0;
    tick();

    // Wrap-around at occupancy 2.
    for (int i = 0; i < 2; i++) begin
      sif.tvalid = 1'b1; sif.tdata = W'(8'hC0 + i);
      tick();
    end
    mif.tready = 1'b1;
    for (int k = 0; k < 3 * DEPTH + 1; k++) begin
      sif.tvalid = 1'b1; sif.tdata = W'(8'hC2 + k);
      #1;
      chk("wrap_data", 32'(mif.tdata), 32'(8'hC0 + k));
      chk("wrap_count", 32'(count), 32'd2);
      tick();
    end
    sif.tvalid = 1'b0;
    tick();
    tick();
    mif.tready = 1'b0;
    #1;
    chk("wrap_empty", 32'(count), 32'd0);

    // Flush at count 3 with a simultaneous push and pop.
    for (int i = 0; i < 3; i++) begin
      sif.tvalid = 1'b1; sif.tdata = W'(8'hD0 + i);
      tick();
    end
    chk("pre_flush_count", 32'(count), 32'd3);
    out_log.delete();
    sif.tvalid = 1'b1; sif.tdata = 8'hFF; mif.tready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; sif.tvalid = 1'b0;
    #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_mvalid", 32'(mif.tvalid), 32'd0);
    chk("flush_sready", 32'(sif.tready), 32'd1);
    tick();
    tick();
    chk("flush_nothing_out", 32'(out_log.size()), 32'd0);

    // Empty FIFO, single beat with the consumer ready.
    mif.tready = 1'b1; sif.tvalid = 1'b1; sif.tdata = 8'h55;
    #1;
`ifdef AXIS_FIFO_BYPASS_EN
    chk("byp_same_valid", 32'(mif.tvalid), 32'd1);
    chk("byp_same_data", 32'(mif.tdata), 32'h55);
    tick();
    sif.tvalid = 1'b0;
    #1;
    chk("byp_count", 32'(count), 32'd0);
    chk("byp_after_valid", 32'(mif.tvalid), 32'd0);
`else
    chk("nobyp_same_valid", 32'(mif.tvalid), 32'd0);
    tick();
    sif.tvalid = 1'b0;
    #1;
    chk("nobyp_count", 32'(count), 32'd1);
    chk("nobyp_valid", 32'(mif.tvalid), 32'd1);
    chk("nobyp_data", 32'(mif.tdata), 32'h55);
    tick();
    chk("nobyp_count_after", 32'(count), 32'd0);
    chk("nobyp_valid_after", 32'(mif.tvalid), 32'd0);
`endif
    mif.tready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
